// File: rtl/clk_rate_pkg.sv
// Shared types and helpers for the clock-rate monitor (test-side counter and ref-side sampler).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package clk_rate_pkg;

  // Largest supported settle window; the settle counter is 8 bits wide.
  localparam int SETTLE_MAX = 255;

  // Width the Gray helpers operate on; callers zero-extend and truncate.
  localparam int GRAY_W = 64;

  // Test-domain counter state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_SAT    = 2'd3
  } rate_state_t;

  // Binary to Gray. Zero-extended inputs give the correct narrow result in the low bits.
  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary (prefix XOR from the MSB down). Used by the ref-side sampler.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/clk_test_gray_counter.sv
// Counts clk_test_buf edges in a reset-bounded window; exports a registered Gray count for CDC.
// Latency: count_bin and count_gray update together on the same edge (no relative skew).
// Backpressure: none; count_en low simply pauses the count.
module clk_test_gray_counter
  import clk_rate_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int SETTLE_CYCLES = 0,
  parameter int SATURATE      = 1
) (
  input  logic                     clk_test_buf,
  input  logic                     async_reset_clk_test,
  input  logic                     count_en,
  output logic [COUNTER_WIDTH-1:0] count_gray,
  output logic [COUNTER_WIDTH-1:0] count_bin,
  output logic                     counting,
  output logic                     saturated
);

  // Reject parameter values the hardware cannot represent.
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("clk_test_gray_counter: SETTLE_CYCLES out of range 0..255");
  end
  if (COUNTER_WIDTH < 1 || COUNTER_WIDTH > GRAY_W) begin : g_bad_width
    $error("clk_test_gray_counter: COUNTER_WIDTH out of range 1..64");
  end

  localparam bit                     HAS_SETTLE  = (SETTLE_CYCLES > 0);
  localparam bit                     DO_SAT      = (SATURATE != 0);
  // Value of the settle counter on the last SETTLE edge (unused when HAS_SETTLE is 0).
  localparam logic [7:0]             SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONES  = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);

  rate_state_t              state, state_next;
  logic [7:0]               settle_cnt, settle_next;
  logic [COUNTER_WIDTH-1:0] bin_next;
  logic [COUNTER_WIDTH-1:0] gray_next;
  logic                     sat_next;
  logic                     counting_next;

  // Next-state, next-count and flag logic; everything defaults to hold.
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    bin_next    = count_bin;
    sat_next    = saturated;
    case (state)
      ST_IDLE: begin
        // The first edge out of reset only leaves IDLE; it is never counted.
        state_next = HAS_SETTLE ? ST_SETTLE : ST_COUNT;
      end
      ST_SETTLE: begin
        settle_next = settle_cnt + 8'd1;
        if (settle_cnt == SETTLE_LAST) begin
          state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (count_en) begin
          if (DO_SAT && (count_bin == CNT_ONES)) begin
            // Hold at all-ones and flag it on the same edge.
            state_next = ST_SAT;
            sat_next   = 1'b1;
          end else begin
            // Natural modulo-2^W wrap when saturation is disabled.
            bin_next = count_bin + CNT_ONE;
          end
        end
      end
      ST_SAT: begin
        state_next = ST_SAT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    counting_next = (state_next == ST_COUNT);
    // Gray is derived from the next binary value so both registers agree every cycle.
    gray_next     = COUNTER_WIDTH'(bin2gray(GRAY_W'(bin_next)));
  end

  // State, counters and outputs; reset clears everything asynchronously.
  always_ff @(posedge clk_test_buf or posedge async_reset_clk_test) begin
    if (async_reset_clk_test) begin
      state      <= ST_IDLE;
      settle_cnt <= 8'd0;
      count_bin  <= '0;
      count_gray <= '0;
      counting   <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      count_bin  <= bin_next;
      count_gray <= gray_next;
      counting   <= counting_next;
      saturated  <= sat_next;
    end
  end

endmodule
